// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU condition-code encodings and the op legality check shared
//               by the alu and the issue-side decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational AND/OR/ADD/SUB unit. Illegal op codes yield a
//               zero result with o_legal low, so no X ever leaves this block.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    i_srca,
    input  logic [DATA_WIDTH-1:0]    i_srcb,
    input  logic [OPCODE_LENGTH-1:0] i_op,
    output logic [DATA_WIDTH-1:0]    o_result,
    output logic                     o_legal
);

    // Op codes wider than the ALUCC field are legal only when the upper bits are zero.
    always_comb begin
        o_result = '0;
        o_legal  = op_legal(i_op[3:0]) && ((i_op >> 4) == '0);
        if (o_legal) begin
            case (i_op[3:0])
                ALU_AND: o_result = i_srca & i_srcb;
                ALU_OR:  o_result = i_srca | i_srcb;
                ALU_ADD: o_result = i_srca + i_srcb;
                ALU_SUB: o_result = i_srca - i_srcb;
                default: o_result = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search starting at i_ptr with wrap;
//               returns a one-hot grant and the winner index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [TAG_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [TAG_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        logic [TAG_W-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = TAG_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = w_j;
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one alu among NUM_REQ requesters with a
//               registered, tagged valid/ready result port and delivery counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 4,
    parameter int CNT_W         = 32,
    localparam int TAG_W        = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [DATA_WIDTH-1:0]            res_data,
    output logic [TAG_W-1:0]                 res_tag,
    output logic                             res_err,
    output logic [CNT_W-1:0]                 ops_done
);

    logic [TAG_W-1:0]         r_rr_ptr;
    logic                     r_res_valid;
    logic [DATA_WIDTH-1:0]    r_res_data;
    logic [TAG_W-1:0]         r_res_tag;
    logic                     r_res_err;
    logic [CNT_W-1:0]         r_ops_done;

    logic [NUM_REQ-1:0]       w_grant;
    logic [TAG_W-1:0]         w_idx;
    logic                     w_any;
    logic                     w_can_accept;
    logic                     w_accept;
    logic [DATA_WIDTH-1:0]    w_srca;
    logic [DATA_WIDTH-1:0]    w_srcb;
    logic [OPCODE_LENGTH-1:0] w_op;
    logic [DATA_WIDTH-1:0]    w_alu_result;
    logic                     w_alu_legal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_srca = req_srca[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_srcb = req_srcb[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_op   = req_op[int'(w_idx)*OPCODE_LENGTH +: OPCODE_LENGTH];

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .i_srca   (w_srca),
        .i_srcb   (w_srcb),
        .i_op     (w_op),
        .o_result (w_alu_result),
        .o_legal  (w_alu_legal)
    );

    // A full output register may still accept if it drains on the same edge.
    assign w_can_accept = !r_res_valid || res_ready;
    assign w_accept     = w_any && w_can_accept;
    assign req_ready    = w_grant & {NUM_REQ{w_can_accept && !rst}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
            r_ops_done  <= '0;
        end else begin
            if (w_accept) begin
                r_res_valid <= 1'b1;
                r_res_data  <= w_alu_legal ? w_alu_result : '0;
                r_res_tag   <= w_idx;
                r_res_err   <= !w_alu_legal;
                r_rr_ptr    <= (w_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
            if (r_res_valid && res_ready) begin
                r_ops_done <= r_ops_done + 1'b1;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;
    assign res_err   = r_res_err;
    assign ops_done  = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed vectors for alu_arbiter: reset, ops, round-robin,
//               backpressure, illegal op and counter wrap (CNT_W=4 twin).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int c_DW = 64;
    localparam int c_OL = 4;
    localparam int c_NR = 4;
    localparam int c_TW = 2;

    localparam logic [3:0] c_AND = 4'b0000;
    localparam logic [3:0] c_OR  = 4'b0001;
    localparam logic [3:0] c_ADD = 4'b0010;
    localparam logic [3:0] c_SUB = 4'b0110;
    localparam logic [3:0] c_BAD = 4'b1111;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [c_NR-1:0]          req_valid;
    logic [c_NR-1:0]          req_ready;
    logic [c_NR-1:0]          req_ready4;
    logic [c_NR*c_DW-1:0]     req_srca;
    logic [c_NR*c_DW-1:0]     req_srcb;
    logic [c_NR*c_OL-1:0]     req_op;
    logic                     res_ready;
    logic                     res_valid, res_valid4;
    logic [c_DW-1:0]          res_data, res_data4;
    logic [c_TW-1:0]          res_tag, res_tag4;
    logic                     res_err, res_err4;
    logic [31:0]              ops_done;
    logic [3:0]               ops_done4;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.DATA_WIDTH(c_DW), .OPCODE_LENGTH(c_OL), .NUM_REQ(c_NR), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err), .ops_done(ops_done)
    );

    alu_arbiter #(.DATA_WIDTH(c_DW), .OPCODE_LENGTH(c_OL), .NUM_REQ(c_NR), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
        .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
        .res_valid(res_valid4), .res_ready(res_ready), .res_data(res_data4),
        .res_tag(res_tag4), .res_err(res_err4), .ops_done(ops_done4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input int i, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        req_op[i*c_OL +: c_OL]   = op;
        req_srca[i*c_DW +: c_DW] = a;
        req_srcb[i*c_DW +: c_DW] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_srca  = '0;
        req_srcb  = '0;
        req_op    = '0;
        res_ready = 1'b0;
        tick();
        tick();

        // Reset state, with requests pending
        req_valid = 4'hF;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(res_valid), 64'h0);
        chk("rst_data",  res_data, 64'h0);
        chk("rst_tag",   64'(res_tag), 64'h0);
        chk("rst_err",   64'(res_err), 64'h0);
        chk("rst_ops",   64'(ops_done), 64'h0);

        tick();
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'h2);

        // Single ops
        setop(0, c_ADD, 64'd5, 64'd7);
        req_valid = 4'b0001;
        #1;
        chk("add_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        chk("add_valid", 64'(res_valid), 64'h1);
        chk("add_data",  res_data, 64'd12);
        chk("add_tag",   64'(res_tag), 64'h0);
        chk("add_err",   64'(res_err), 64'h0);
        setop(1, c_SUB, 64'd3, 64'd5);
        req_valid = 4'b0010;
        #1;
        chk("bp_ready0", 64'(req_ready), 64'h0);
        res_ready = 1'b1;
        #1;
        chk("drain_grant", 64'(req_ready), 64'h2);
        tick();
        chk("sub_data", res_data, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_tag",  64'(res_tag), 64'h1);
        chk("sub_ops",  64'(ops_done), 64'd1);
        req_valid = '0;
        tick();
        chk("drain_valid", 64'(res_valid), 64'h0);
        chk("drain_ops",   64'(ops_done), 64'd2);

        // Short async reset pulse between edges
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("pulse_ops", 64'(ops_done), 64'h0);

        // Round-robin, back-to-back
        for (int i = 0; i < c_NR; i++) setop(i, c_ADD, 64'(i + 1), 64'(10 * (i + 1)));
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_tag",  64'(res_tag), 64'(k % 4));
            chk("rr_data", res_data, 64'(11 * ((k % 4) + 1)));
        end
        req_valid = '0;
        tick();
        chk("rr_ops",   64'(ops_done), 64'd8);
        chk("rr_valid", 64'(res_valid), 64'h0);

        // Backpressure
        req_valid = 4'hF;
        tick();
        chk("bp_first_tag", 64'(res_tag), 64'h0);
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'h0);
            tick();
            chk("bp_tag",  64'(res_tag), 64'h0);
            chk("bp_data", res_data, 64'd11);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(req_ready), 64'h2);
        tick();
        chk("bp_next_tag",  64'(res_tag), 64'h1);
        chk("bp_next_data", res_data, 64'd22);
        chk("bp_ops",       64'(ops_done), 64'd9);
        req_valid = '0;
        tick();
        chk("bp_drain_ops", 64'(ops_done), 64'd10);

        // Illegal op, then legal OR and AND
        setop(2, c_BAD, 64'd1, 64'd2);
        req_valid = 4'b0100;
        tick();
        chk("ill_err",  64'(res_err), 64'h1);
        chk("ill_data", res_data, 64'h0);
        chk("ill_tag",  64'(res_tag), 64'h2);
        setop(3, c_OR, 64'hF0, 64'h0F);
        req_valid = 4'b1000;
        tick();
        chk("or_err",  64'(res_err), 64'h0);
        chk("or_data", res_data, 64'hFF);
        chk("or_tag",  64'(res_tag), 64'h3);
        chk("or_ops",  64'(ops_done), 64'd11);
        setop(0, c_AND, 64'hFF00, 64'h0FF0);
        req_valid = 4'b0001;
        tick();
        chk("and_data", res_data, 64'h0F00);
        chk("and_tag",  64'(res_tag), 64'h0);
        req_valid = '0;
        tick();
        chk("ill_ops", 64'(ops_done), 64'd13);

        // Reset with a result in flight
        setop(2, c_ADD, 64'd3, 64'd30);
        setop(3, c_ADD, 64'd4, 64'd40);
        req_valid = 4'hF;
        tick();
        chk("mid_pre_valid", 64'(res_valid), 64'h1);
        chk("mid_pre_tag",   64'(res_tag), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_valid", 64'(res_valid), 64'h0);
        chk("mid_data",  res_data, 64'h0);
        chk("mid_tag",   64'(res_tag), 64'h0);
        chk("mid_ops",   64'(ops_done), 64'h0);
        chk("mid_ready", 64'(req_ready), 64'h0);
        rst       = 1'b0;
        req_valid = 4'b1100;
        #1;
        chk("mid_first_grant", 64'(req_ready), 64'h4);

        // 17 deliveries: 32-bit counter reads 17, 4-bit twin wraps to 1
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("wrap_tag",  64'(res_tag), (k % 2 == 0) ? 64'h2 : 64'h3);
            chk("wrap_data", res_data, (k % 2 == 0) ? 64'd33 : 64'd44);
            if (k == 16) chk("wrap_ops4_zero", 64'(ops_done4), 64'h0);
        end
        req_valid = '0;
        tick();
        chk("wrap_ops",  64'(ops_done), 64'd17);
        chk("wrap_ops4", 64'(ops_done4), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
